// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: ALU control encodings and FSM states.
package alu_mul_seq_pkg;

  // ALU control bit order: ex,nx,ey,ny,f,no (ex/ey pass X/Y through, zero them when low)
  localparam logic [5:0] C_EX = 6'd32;
  localparam logic [5:0] C_NX = 6'd16;
  localparam logic [5:0] C_EY = 6'd8;
  localparam logic [5:0] C_NY = 6'd4;
  localparam logic [5:0] C_F  = 6'd2;
  localparam logic [5:0] C_NO = 6'd1;

  localparam logic [5:0] C_ADD  = C_EX | C_EY | C_F;
  localparam logic [5:0] C_ZERO = C_F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// MSB-first shift-and-add multiplier that borrows the external combinational ALU,
// issuing one add per cycle (the shift is acc+acc).
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             product_z,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_c,
  output logic             alu_en_bar,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // product_z comes from the registered product, so the ALU Z flag is not needed
  logic unused_alu_z;
  assign unused_alu_z = alu_z;

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign alu_en_bar = 1'b1;

  always_comb begin
    alu_x = '0;
    alu_y = '0;
    alu_c = C_ZERO;
    case (state)
      ST_SHIFT: begin
        alu_x = acc;
        alu_y = acc;
        alu_c = C_ADD;
      end
      ST_ADD: begin
        alu_x = acc;
        alu_y = mcand;
        alu_c = C_ADD;
      end
      default: ;
    endcase
  end

  // product is captured on the final SHIFT/ADD so it is already valid while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product   <= '0;
      product_z <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            if (ZERO_SKIP && ((a == '0) || (b == '0))) begin
              state     <= ST_DONE;
              product   <= '0;
              product_z <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          acc <= alu_out;
          if (mplier[WIDTH-1]) begin
            state <= ST_ADD;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            product   <= alu_out;
            product_z <= (alu_out == '0);
          end else begin
            cnt    <= cnt + CNT_W'(1);
            mplier <= mplier << 1;
          end
        end
        ST_ADD: begin
          acc <= alu_out;
          if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            product   <= alu_out;
            product_z <= (alu_out == '0);
          end else begin
            cnt    <= cnt + CNT_W'(1);
            mplier <= mplier << 1;
            state  <= ST_SHIFT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (zero-skip on/off), each beside a behavioural ALU.
module tb_alu_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        busy0, done0, product_z0, alu_en_bar0, alu_z0;
  logic [15:0] product0, alu_x0, alu_y0, alu_out0;
  logic [5:0]  alu_c0;
  logic        busy1, done1, product_z1, alu_en_bar1, alu_z1;
  logic [15:0] product1, alu_x1, alu_y1, alu_out1;
  logic [5:0]  alu_c1;

  function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? x : 16'h0;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? y : 16'h0;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? (xx + yy) : (xx & yy);
    return c[0] ? ~o : o;
  endfunction

  assign alu_out0 = alu_model(alu_x0, alu_y0, alu_c0);
  assign alu_z0   = (alu_out0 == 16'h0);
  assign alu_out1 = alu_model(alu_x1, alu_y1, alu_c1);
  assign alu_z1   = (alu_out1 == 16'h0);

  alu_mul_seq #(.WIDTH(16), .ZERO_SKIP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(product0), .product_z(product_z0),
    .alu_x(alu_x0), .alu_y(alu_y0), .alu_c(alu_c0), .alu_en_bar(alu_en_bar0),
    .alu_out(alu_out0), .alu_z(alu_z0)
  );

  alu_mul_seq #(.WIDTH(16), .ZERO_SKIP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(product1), .product_z(product_z1),
    .alu_x(alu_x1), .alu_y(alu_y1), .alu_c(alu_c1), .alu_en_bar(alu_en_bar1),
    .alu_out(alu_out1), .alu_z(alu_z1)
  );

  int checks = 0;
  int failures = 0;
  logic [37:0] exp_q[$];  // {alu_x, alu_y, alu_c} per busy cycle

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    int          lat;
    bit          poke;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v;
    else start0 = v;
  endtask

  task automatic sample(input int sel, output logic bsy, output logic dn,
                        output logic [15:0] p, output logic pz,
                        output logic [37:0] drv, output logic enb);
    bsy = sel ? busy1 : busy0;
    dn  = sel ? done1 : done0;
    p   = sel ? product1 : product0;
    pz  = sel ? product_z1 : product_z0;
    drv = sel ? {alu_x1, alu_y1, alu_c1} : {alu_x0, alu_y0, alu_c0};
    enb = sel ? alu_en_bar1 : alu_en_bar0;
  endtask

  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_p, input int exp_lat, input bit poke);
    logic [15:0] acc;
    logic [37:0] drv, e;
    logic        bsy, dn, pz, enb;
    logic [15:0] p;
    int          cycle, done_cycle;
    bit          seen;
    exp_q.delete();
    if (!(sel == 0 && (av == 16'h0 || bv == 16'h0))) begin
      acc = 16'h0;
      for (int i = 15; i >= 0; i--) begin
        exp_q.push_back({acc, acc, 6'd42});
        acc = acc + acc;
        if (bv[i]) begin
          exp_q.push_back({acc, av, 6'd42});
          acc = acc + av;
        end
      end
    end
    exp_q.push_back({16'h0, 16'h0, 6'd2});

    @(negedge clk);
    a = av;
    b = bv;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    a = ~av;
    b = ~bv;
    cycle = 1;
    done_cycle = 0;
    seen = 0;
    while (!seen && cycle <= 40) begin
      sample(sel, bsy, dn, p, pz, drv, enb);
      if (exp_q.size() == 0) begin
        fail_now("queue_overrun", cycle, exp_lat);
        e = 38'h0;
      end else begin
        e = exp_q.pop_front();
      end
      check("alu_drive", drv, e);
      check("alu_en_bar", enb, 1'b1);
      check("busy_done", {bsy, dn}, {1'b1, exp_q.size() == 0});
      if (dn) begin
        seen = 1;
        done_cycle = cycle;
        check("product", p, exp_p);
        check("product_z", pz, exp_p == 16'h0);
        if (poke) begin
          a = 16'h0003;
          b = 16'h0003;
          set_start(sel, 1'b1);
        end
      end else if (cycle == 3) begin
        a = 16'h0055;
        b = 16'h0101;
        set_start(sel, 1'b1);
      end
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      if (!seen) cycle++;
    end
    if (!seen) fail_now("done_timeout", cycle, exp_lat);
    else check("latency", done_cycle, exp_lat);
    sample(sel, bsy, dn, p, pz, drv, enb);
    check("after_busy_done", {bsy, dn}, 2'b00);
    check("after_product", {p, pz}, {exp_p, exp_p == 16'h0});
    check("after_drive", drv, {16'h0, 16'h0, 6'd2});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 16'd3,     16'd5,     16'd15,     19, 1'b1};
    vecs[1] = '{0, 16'hFFFF,  16'hFFFF,  16'h0001,   33, 1'b0};
    vecs[2] = '{0, 16'd300,   16'd300,   16'd24464,  21, 1'b0};
    vecs[3] = '{0, 16'h8000,  16'd2,     16'h0000,   18, 1'b0};
    vecs[4] = '{0, 16'd0,     16'd1234,  16'h0000,    1, 1'b0};
    vecs[5] = '{1, 16'd0,     16'd1234,  16'h0000,   22, 1'b0};
    vecs[6] = '{0, 16'd7,     16'd9,     16'd63,     19, 1'b1};
    vecs[7] = '{0, 16'h1234,  16'h0000,  16'h0000,    1, 1'b1};
    vecs[8] = '{0, 16'h1234,  16'h0003,  16'h369C,   19, 1'b0};
    vecs[9] = '{0, 16'hFFFF,  16'h0001,  16'hFFFF,   18, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy_done0", {busy0, done0}, 2'b00);
    check("rst_product0", {product0, product_z0}, {16'h0, 1'b1});
    check("rst_drive0", {alu_x0, alu_y0, alu_c0, alu_en_bar0}, {16'h0, 16'h0, 6'd2, 1'b1});
    check("rst_state1", {busy1, done1, product1, product_z1}, {2'b00, 16'h0, 1'b1});
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, vecs[i].poke);

    // reset in the middle of an operation, with an ignored start at cycle 5
    @(negedge clk);
    a = 16'd7;
    b = 16'd9;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("mid_busy_done", {busy0, done0}, 2'b10);
      start0 = (c == 5);
      if (c == 5) begin
        a = 16'd2;
        b = 16'd2;
      end
      if (c == 8) break;
      @(posedge clk);
      #1;
    end
    start0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy_done", {busy0, done0}, 2'b00);
    check("abort_product", {product0, product_z0}, {16'h0, 1'b1});
    check("abort_drive", alu_c0, 6'd2);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'd2, 16'd2, 16'd4, 18, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
